// File: rtl/sevenseg_scan_ctrl.sv
// Four-digit common-anode seven-segment scanner with blank gaps between digits,
// optional leading-zero suppression and frame-synchronous double-buffered updates.
module sevenseg_scan_ctrl #(
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [6:0]  a_to_g,
  output logic        dp,
  output logic [3:0]  an,
  output logic        upd_pend,
  output logic        frame_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  logic [CW-1:0] cnt;
  logic [1:0]    dig;
  logic [15:0]   disp_data, pend_data;
  logic [3:0]    disp_dp, pend_dp;
  logic          slot_end, commit, blank;
  logic [3:0]    nib, sup;

  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'h0: dec7 = 7'b0000001;
      4'h1: dec7 = 7'b1001111;
      4'h2: dec7 = 7'b0010010;
      4'h3: dec7 = 7'b0000110;
      4'h4: dec7 = 7'b1001100;
      4'h5: dec7 = 7'b0100100;
      4'h6: dec7 = 7'b0100000;
      4'h7: dec7 = 7'b0001111;
      4'h8: dec7 = 7'b0000000;
      4'h9: dec7 = 7'b0000100;
      4'hA: dec7 = 7'b0001000;
      4'hB: dec7 = 7'b1100000;
      4'hC: dec7 = 7'b0110001;
      4'hD: dec7 = 7'b1000010;
      4'hE: dec7 = 7'b0110000;
      default: dec7 = 7'b0111000;
    endcase
  endfunction

  assign slot_end   = (cnt == CNT_LAST);
  assign commit     = slot_end && (dig == 2'd3);
  assign frame_tick = commit;

  always_comb begin
    nib = disp_data[3:0];
    case (dig)
      2'd0: nib = disp_data[3:0];
      2'd1: nib = disp_data[7:4];
      2'd2: nib = disp_data[11:8];
      default: nib = disp_data[15:12];
    endcase
  end

  // digit k is dark when it and every more significant nibble are zero
  assign sup = lz_en ? {(disp_data[15:12] == 4'h0), (disp_data[15:8] == 8'h00),
                        (disp_data[15:4] == 12'h000), 1'b0} : 4'b0000;

  assign blank = !en || (cnt < CNT_BLANK) || sup[dig];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt       <= '0;
      dig       <= 2'd0;
      disp_data <= 16'h0000;
      disp_dp   <= 4'b0000;
      pend_data <= 16'h0000;
      pend_dp   <= 4'b0000;
      upd_pend  <= 1'b0;
      a_to_g    <= 7'b1111111;
      dp        <= 1'b1;
      an        <= 4'b1111;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        dig <= dig + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (load) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
      end

      // a load landing on the commit cycle bypasses the pending buffer
      if (commit) begin
        upd_pend <= 1'b0;
        if (load) begin
          disp_data <= data_in;
          disp_dp   <= dp_in;
        end else if (upd_pend) begin
          disp_data <= pend_data;
          disp_dp   <= pend_dp;
        end
      end else if (load) begin
        upd_pend <= 1'b1;
      end

      if (blank) begin
        a_to_g <= 7'b1111111;
        dp     <= 1'b1;
        an     <= 4'b1111;
      end else begin
        a_to_g <= dec7(nib);
        dp     <= ~disp_dp[dig];
        an     <= ~(4'b0001 << dig);
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl (PRESCALE=8, BLANK_CYC=2): a cycle model
// queues the expected registered outputs each cycle and they are popped after the edge.
module tb_sevenseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        en = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic        lz_en = 1'b0;
  logic [6:0]  a_to_g;
  logic        dp;
  logic [3:0]  an;
  logic        upd_pend;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          m_cnt, m_dig;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_disp_dp, m_pend_dp;
  logic        m_upd;
  logic [11:0] exp_q[$];

  sevenseg_scan_ctrl #(.PRESCALE(8), .BLANK_CYC(2)) dut (
    .clk(clk), .clr_n(clr_n), .en(en), .load(load), .data_in(data_in),
    .dp_in(dp_in), .lz_en(lz_en), .a_to_g(a_to_g), .dp(dp), .an(an),
    .upd_pend(upd_pend), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] t[16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                          7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return t[v];
  endfunction

  function automatic logic [11:0] model_out();
    logic [3:0] v;
    logic       dark;
    v = 4'((m_disp >> (4 * m_dig)) & 16'hF);
    dark = 1'b0;
    if (lz_en && m_dig > 0 && (m_disp >> (4 * m_dig)) == 16'h0) dark = 1'b1;
    if (!en || m_cnt < 2 || dark) return 12'hFFF;
    return {seg_of(v), ~m_disp_dp[m_dig], ~(4'b0001 << m_dig)};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_dig = 0; m_disp = 0; m_pend = 0;
    m_disp_dp = 0; m_pend_dp = 0; m_upd = 0;
    exp_q.delete();
  endtask

  task automatic model_advance();
    if (m_dig == 3 && m_cnt == 7) begin
      if (load) begin
        m_disp = data_in; m_disp_dp = dp_in;
        m_pend = data_in; m_pend_dp = dp_in;
      end else if (m_upd) begin
        m_disp = m_pend; m_disp_dp = m_pend_dp;
      end
      m_upd = 1'b0;
    end else if (load) begin
      m_pend = data_in; m_pend_dp = dp_in; m_upd = 1'b1;
    end
    if (m_cnt == 7) begin
      m_cnt = 0; m_dig = (m_dig + 1) % 4;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  // one clock: queue expectation, take the edge, compare at edge+1
  task automatic step();
    logic [11:0] e;
    exp_q.push_back(model_out());
    @(posedge clk);
    model_advance();
    #1;
    cyc++;
    e = exp_q.pop_front();
    checks++;
    if ({a_to_g, dp, an} !== e) begin
      errors++;
      $display("FAIL outputs cyc=%0d got seg=%b dp=%b an=%b want seg=%b dp=%b an=%b",
               cyc, a_to_g, dp, an, e[11:5], e[4], e[3:0]);
    end
    checks++;
    if (upd_pend !== m_upd) begin
      errors++;
      $display("FAIL upd_pend cyc=%0d got %b want %b", cyc, upd_pend, m_upd);
    end
    checks++;
    if (frame_tick !== (m_dig == 3 && m_cnt == 7)) begin
      errors++;
      $display("FAIL frame_tick cyc=%0d got %b want %b", cyc, frame_tick, (m_dig == 3 && m_cnt == 7));
    end
  endtask

  task automatic run_until(input int d, input int c);
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_dig == d && m_cnt == c) found = 1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL run_until timeout got dig=%0d cnt=%0d want dig=%0d cnt=%0d", m_dig, m_cnt, d, c);
    end
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    #22;
    checks++;
    if ({a_to_g, dp, an, upd_pend, frame_tick} !== 14'b1111111_1_1111_0_0) begin
      errors++;
      $display("FAIL reset_state got seg=%b dp=%b an=%b upd=%b ft=%b want all blank, upd=0 ft=0",
               a_to_g, dp, an, upd_pend, frame_tick);
    end
    @(posedge clk); #1;
    clr_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle();
    int ft = 0;
    for (int k = 1; k <= 64; k++) begin
      step();
      if (frame_tick) ft++;
      if (k <= 2) begin
        checks++;
        if (an !== 4'b1111) begin
          errors++; $display("FAIL idle_blank k=%0d got an=%b want 1111", k, an);
        end
      end else if (k <= 8) begin
        checks++;
        if (an !== 4'b1110 || a_to_g !== 7'b0000001) begin
          errors++; $display("FAIL idle_dig0 k=%0d got an=%b seg=%b want 1110 0000001", k, an, a_to_g);
        end
      end
    end
    checks++;
    if (ft != 2) begin
      errors++; $display("FAIL idle_frame_ticks got %0d want 2", ft);
    end
  endtask

  task automatic test_load();
    int seen[4] = '{0, 0, 0, 0};
    run_until(1, 3);
    load = 1'b1; data_in = 16'h1111; dp_in = 4'b1111;
    step();
    data_in = 16'h12AF; dp_in = 4'b0100;
    step();
    load = 1'b0;
    checks++;
    if (upd_pend !== 1'b1) begin
      errors++; $display("FAIL load_pend got %b want 1", upd_pend);
    end
    for (int i = 0; i < 40 && !(m_dig == 3 && m_cnt == 7); i++) begin
      step();
      checks++;
      if (an !== 4'b1111 && a_to_g !== 7'b0000001) begin
        errors++; $display("FAIL load_no_tear got seg=%b want 0000001", a_to_g);
      end
    end
    step();
    for (int i = 0; i < 32; i++) begin
      step();
      case (an)
        4'b1110: begin seen[0]++; checks++; if ({a_to_g, dp} !== 8'b0111000_1) begin errors++; $display("FAIL load_d0 got %b%b want 01110001", a_to_g, dp); end end
        4'b1101: begin seen[1]++; checks++; if ({a_to_g, dp} !== 8'b0001000_1) begin errors++; $display("FAIL load_d1 got %b%b want 00010001", a_to_g, dp); end end
        4'b1011: begin seen[2]++; checks++; if ({a_to_g, dp} !== 8'b0010010_0) begin errors++; $display("FAIL load_d2 got %b%b want 00100100", a_to_g, dp); end end
        4'b0111: begin seen[3]++; checks++; if ({a_to_g, dp} !== 8'b1001111_1) begin errors++; $display("FAIL load_d3 got %b%b want 10011111", a_to_g, dp); end end
        default: ;
      endcase
    end
    checks++;
    if (seen[0] != 6 || seen[1] != 6 || seen[2] != 6 || seen[3] != 6) begin
      errors++; $display("FAIL load_slots got %0d %0d %0d %0d want 6 each", seen[0], seen[1], seen[2], seen[3]);
    end
  endtask

  task automatic test_load_on_commit();
    int n5 = 0;
    run_until(3, 7);
    load = 1'b1; data_in = 16'h0005; dp_in = 4'b0000;
    step();
    load = 1'b0;
    checks++;
    if (upd_pend !== 1'b0) begin
      errors++; $display("FAIL commit_load_pend got %b want 0", upd_pend);
    end
    for (int i = 0; i < 32; i++) begin
      step();
      if (an == 4'b1110) begin
        n5++;
        checks++;
        if (a_to_g !== 7'b0100100) begin
          errors++; $display("FAIL commit_load_d0 got %b want 0100100", a_to_g);
        end
      end
    end
    checks++;
    if (n5 != 6) begin
      errors++; $display("FAIL commit_load_slots got %0d want 6", n5);
    end
  endtask

  task automatic test_lz();
    int d3 = 0;
    lz_en = 1'b1;
    run_until(0, 4);
    load = 1'b1; data_in = 16'h0030; dp_in = 4'b0000;
    step();
    load = 1'b0;
    run_until(3, 7);
    step();
    for (int i = 0; i < 32; i++) begin
      step();
      checks++;
      if (an == 4'b0111 || an == 4'b1011) begin
        errors++; $display("FAIL lz_dark got an=%b want digits 3,2 off", an);
      end
      if (an == 4'b1101) begin
        checks++;
        if (a_to_g !== 7'b0000110) begin errors++; $display("FAIL lz_d1 got %b want 0000110", a_to_g); end
      end
      if (an == 4'b1110) begin
        checks++;
        if (a_to_g !== 7'b0000001) begin errors++; $display("FAIL lz_d0 got %b want 0000001", a_to_g); end
      end
    end
    lz_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (an == 4'b0111) begin
        d3++;
        checks++;
        if (a_to_g !== 7'b0000001) begin errors++; $display("FAIL nolz_d3 got %b want 0000001", a_to_g); end
      end
    end
    checks++;
    if (d3 != 6) begin
      errors++; $display("FAIL nolz_slots got %0d want 6", d3);
    end
  endtask

  task automatic test_enable();
    run_until(1, 4);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i > 0) begin
        checks++;
        if ({a_to_g, dp, an} !== 12'hFFF) begin
          errors++; $display("FAIL en_blank i=%0d got %b %b %b want all ones", i, a_to_g, dp, an);
        end
      end
    end
    en = 1'b1;
    step(); step(); step();
    checks++;
    if (an !== 4'b1110) begin
      errors++; $display("FAIL en_resume got an=%b want 1110", an);
    end
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_async_reset();
    load = 1'b1; data_in = 16'hBEEF; dp_in = 4'b1010;
    step();
    load = 1'b0;
    run_until(2, 5);
    #3;
    clr_n = 1'b0;
    #1;
    checks++;
    if ({a_to_g, dp, an, upd_pend} !== 13'b1111111_1_1111_0) begin
      errors++; $display("FAIL async_reset got seg=%b dp=%b an=%b upd=%b want blank upd=0",
                         a_to_g, dp, an, upd_pend);
    end
    model_reset();
    @(posedge clk); #1;
    clr_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (upd_pend !== 1'b0 || (an !== 4'b1111 && a_to_g !== 7'b0000001)) begin
        errors++; $display("FAIL reset_lost_pend got upd=%b seg=%b want 0 0000001", upd_pend, a_to_g);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load();
    test_load_on_commit();
    test_lz();
    test_enable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
